// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared types and constants for the bit-serial subtractor
//                (FSM state encoding and default operand width).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Default operand/result width of the serial subtractor.
    localparam int c_DEFAULT_NBITS = 32;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/FullSubtractor_GL.sv
`default_nettype none
// ============================================================================
//  Module      : FullSubtractor_GL
//  Description : Single-bit combinational full-subtractor cell computing
//                in0 - in1 - bin with difference and borrow-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module FullSubtractor_GL
    import serial_sub_pkg::*;
(
    input  logic in0,
    input  logic in1,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference is the parity of the three inputs; a borrow is needed when
    // the minuend bit cannot cover the subtrahend bit plus incoming borrow.
    always_comb begin
        diff = in0 ^ in1 ^ bin;
        bout = (~in0 & in1) | (~in0 & bin) | (in1 & bin);
    end

endmodule
`default_nettype wire

// File: rtl/serial_sub_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_rtl
//  Description : Bit-serial subtractor, diff = in0 - in1 (mod 2^NBITS),
//                one bit per cycle LSB first through a single full-subtractor
//                cell with a registered borrow. Operands and results move
//                over val/rdy stream handshakes.
//                Optional macro SERIAL_SUB_OVERFLOW_EN adds a registered
//                signed-overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_rtl
    import serial_sub_pkg::*;
#(
    parameter int NBITS = c_DEFAULT_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int              c_CW       = $clog2(NBITS) + 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(NBITS - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [NBITS-1:0] r_a_sh;
    logic [NBITS-1:0] r_b_sh;
    logic [NBITS-1:0] r_res;
    logic             r_bor;
    logic [c_CW-1:0]  r_cnt;

    logic [NBITS-1:0] r_diff;
    logic             r_borrow;

    logic             w_accept;
    logic             w_calc;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [NBITS-1:0] w_res_nxt;

    assign w_accept  = (r_state == IDLE) && istream_val;
    assign w_calc    = (r_state == CALC);
    assign w_last    = w_calc && (r_cnt == c_CNT_LAST);
    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign w_res_nxt = {w_d, r_res[NBITS-1:1]};

    FullSubtractor_GL u_cell (
        .in0  (r_a_sh[0]),
        .in1  (r_b_sh[0]),
        .bin  (r_bor),
        .diff (w_d),
        .bout (w_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; no operand accept while a result is pending.
    always_comb begin
        w_state_nxt = r_state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        case (r_state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, running borrow, partial result and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a_sh <= in0;
            r_b_sh <= in1;
            r_res  <= '0;
            r_bor  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_calc) begin
            r_a_sh <= {1'b0, r_a_sh[NBITS-1:1]};
            r_b_sh <= {1'b0, r_b_sh[NBITS-1:1]};
            r_res  <= w_res_nxt;
            r_bor  <= w_bout;
            r_cnt  <= r_cnt + c_CNT_ONE;
        end
    end

    // Visible result registers update only on the final bit and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_ovf;

    // On the final bit the shift-register LSBs hold the operand sign bits:
    // overflow when the operand signs differ and the result sign differs from in0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a_sh[0] ^ r_b_sh[0]) & (r_a_sh[0] ^ w_d);
        end
    end

    assign overflow = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_sub_rtl
//  Description : Self-checking bench for serial_sub_rtl with an 8-bit and a
//                32-bit instance, a transaction-level reference model and
//                randomized operands and val/rdy stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_rtl;

    localparam int c_NRAND = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ival [2];
    logic        ordy [2];
    logic [31:0] op0  [2];
    logic [31:0] op1  [2];
    logic        irdy [2];
    logic        oval [2];
    logic [31:0] dd   [2];
    logic        bo   [2];
    logic        ov   [2];
    logic [7:0]  d8;
    logic [31:0] d32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dd[0] = {24'h0, d8};
    assign dd[1] = d32;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic ov8, ov32;
    assign ov[0] = ov8;
    assign ov[1] = ov32;
`else
    assign ov[0] = 1'b0;
    assign ov[1] = 1'b0;
`endif

    serial_sub_rtl #(.NBITS(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .istream_val (ival[0]),
        .istream_rdy (irdy[0]),
        .in0         (op0[0][7:0]),
        .in1         (op1[0][7:0]),
        .ostream_val (oval[0]),
        .ostream_rdy (ordy[0]),
        .diff        (d8),
        .borrow      (bo[0])
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow    (ov8)
`endif
    );

    serial_sub_rtl #(.NBITS(32)) u_dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .istream_val (ival[1]),
        .istream_rdy (irdy[1]),
        .in0         (op0[1]),
        .in1         (op1[1]),
        .ostream_val (oval[1]),
        .ostream_rdy (ordy[1]),
        .diff        (d32),
        .borrow      (bo[1])
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow    (ov32)
`endif
    );

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic int nb(input int k);
        return (k == 0) ? 8 : 32;
    endfunction

    function automatic logic [31:0] mask_of(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Signed overflow: true signed difference falls outside the NBITS range.
    function automatic logic ref_ovf(input int k, input logic [31:0] a, input logic [31:0] b);
        longint span, half, sa, sb, r;
        span = longint'(1) << nb(k);
        half = span / 2;
        sa   = {32'h0, a & mask_of(k)};
        sb   = {32'h0, b & mask_of(k)};
        if (sa >= half) sa = sa - span;
        if (sb >= half) sb = sb - span;
        r = sa - sb;
        return (r < -half) || (r >= half);
    endfunction

    function automatic void chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h at t=%0t", name, k, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model and per-cycle compare
    // ------------------------------------------------------------------
    bit          mon_en = 1'b0;
    bit          pend [2];
    int          age  [2];
    int          ncomp [2];
    logic [31:0] e_d [2];
    logic        e_b [2];
    logic        e_o [2];
    logic [31:0] l_d [2];
    logic        l_b [2];
    logic        l_o [2];
    bit          m_done;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    chk("rst_irdy", k, irdy[k], 1);
                    chk("rst_oval", k, oval[k], 0);
                    chk("rst_diff", k, dd[k], 0);
                    chk("rst_borrow", k, bo[k], 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    chk("rst_ovf", k, ov[k], 0);
`endif
                    pend[k] = 1'b0;
                    age[k]  = 0;
                    l_d[k]  = '0;
                    l_b[k]  = 1'b0;
                    l_o[k]  = 1'b0;
                end else begin
                    m_done = pend[k] && (age[k] >= nb(k) + 1);
                    chk("irdy", k, irdy[k], {31'b0, !pend[k]});
                    chk("oval", k, oval[k], {31'b0, m_done});
                    if (m_done) begin
                        chk("diff", k, dd[k], e_d[k]);
                        chk("borrow", k, bo[k], e_b[k]);
`ifdef SERIAL_SUB_OVERFLOW_EN
                        chk("ovf", k, ov[k], e_o[k]);
`endif
                    end else begin
                        chk("hold_diff", k, dd[k], l_d[k]);
                        chk("hold_borrow", k, bo[k], l_b[k]);
`ifdef SERIAL_SUB_OVERFLOW_EN
                        chk("hold_ovf", k, ov[k], l_o[k]);
`endif
                    end
                    if (pend[k]) begin
                        if (m_done && ordy[k]) begin
                            pend[k] = 1'b0;
                            l_d[k]  = e_d[k];
                            l_b[k]  = e_b[k];
                            l_o[k]  = e_o[k];
                            ncomp[k]++;
                        end else begin
                            age[k]++;
                        end
                    end else if (ival[k]) begin
                        pend[k] = 1'b1;
                        age[k]  = 1;
                        e_d[k]  = (op0[k] - op1[k]) & mask_of(k);
                        e_b[k]  = (op0[k] & mask_of(k)) < (op1[k] & mask_of(k));
                        e_o[k]  = ref_ovf(k, op0[k], op1[k]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [31:0] rand_op(input int k);
        logic [31:0] m;
        m = mask_of(k);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return m;
            2:       return (m >> 1) + 32'h1;
            3:       return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    // One directed operation with ostream_rdy high; latency counted from the
    // handshake cycle to the first cycle with ostream_val.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] d, output logic bw, output logic ow, output int lat);
        int n;
        op0[k]  = a;
        op1[k]  = b;
        ival[k] = 1'b1;
        ordy[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irdy[k] && n < 200);
        @(posedge clk);
        #1 ival[k] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!oval[k] && lat < 200);
        d  = dd[k];
        bw = bo[k];
        ow = ov[k];
        @(posedge clk);
        #1;
    endtask

    task automatic rand_drive(input int k);
        int  start;
        int  cyc;
        bit  acc;
        start   = ncomp[k];
        cyc     = 0;
        ival[k] = 1'b0;
        while (ncomp[k] < start + c_NRAND && cyc < 60000) begin
            @(negedge clk);
            acc = ival[k] && irdy[k];
            @(posedge clk);
            #1;
            cyc++;
            if (acc || !ival[k]) begin
                op0[k]  = rand_op(k);
                op1[k]  = rand_op(k);
                ival[k] = acc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            end
            ordy[k] = ($urandom_range(0, 3) != 0);
        end
        chk("rand_completed", k, ncomp[k] - start, c_NRAND);
        ival[k] = 1'b0;
        ordy[k] = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [31:0] rd;
    logic        rb;
    logic        ro;
    int          rl;
    int          n;

    initial begin
        ival[0] = 1'b0; ival[1] = 1'b0;
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        op0[0] = '0; op0[1] = '0;
        op1[0] = '0; op1[1] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("init_irdy", 0, irdy[0], 1);
        chk("init_oval", 0, oval[0], 0);
        chk("init_diff", 0, dd[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Pin the reference model with hand-computed values.
        chk("model_ovf_80_01", 0, ref_ovf(0, 32'h80, 32'h01), 1);
        chk("model_ovf_7f_ff", 0, ref_ovf(0, 32'h7F, 32'hFF), 1);
        chk("model_ovf_05_03", 0, ref_ovf(0, 32'h05, 32'h03), 0);
        chk("model_ovf_32b", 1, ref_ovf(1, 32'h8000_0000, 32'h1), 1);

        run_op(0, 32'h05, 32'h03, rd, rb, ro, rl);
        chk("lat_5_3", 0, rl, 9);
        chk("diff_5_3", 0, rd, 32'h02);
        chk("borrow_5_3", 0, rb, 0);

        run_op(0, 32'h03, 32'h05, rd, rb, ro, rl);
        chk("diff_3_5", 0, rd, 32'hFE);
        chk("borrow_3_5", 0, rb, 1);

        run_op(0, 32'h00, 32'h00, rd, rb, ro, rl);
        chk("diff_0_0", 0, rd, 32'h00);
        chk("borrow_0_0", 0, rb, 0);

        run_op(0, 32'h80, 32'h01, rd, rb, ro, rl);
        chk("diff_80_01", 0, rd, 32'h7F);
        chk("borrow_80_01", 0, rb, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_80_01", 0, ro, 1);
`endif

        run_op(0, 32'h7F, 32'hFF, rd, rb, ro, rl);
        chk("diff_7f_ff", 0, rd, 32'h80);
        chk("borrow_7f_ff", 0, rb, 1);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_7f_ff", 0, ro, 1);
`endif

        // Backpressure with the next operand already waiting.
        op0[0] = 32'h40; op1[0] = 32'h10; ival[0] = 1'b1; ordy[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!irdy[0] && n < 200);
        @(posedge clk);
        #1 op0[0] = 32'h11; op1[0] = 32'h22;
        n = 0;
        do begin @(negedge clk); n++; end while (!oval[0] && n < 200);
        chk("bp_diff", 0, dd[0], 32'h30);
        chk("bp_borrow", 0, bo[0], 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_oval", 0, oval[0], 1);
            chk("bp_hold_diff", 0, dd[0], 32'h30);
            chk("bp_hold_irdy", 0, irdy[0], 0);
        end
        @(posedge clk);
        #1 ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_hs_irdy", 0, irdy[0], 0);
        chk("bp_hs_oval", 0, oval[0], 1);
        @(negedge clk);
        chk("bp_next_irdy", 0, irdy[0], 1);
        chk("bp_next_oval", 0, oval[0], 0);
        @(posedge clk);
        #1 ival[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!oval[0] && n < 200);
        chk("bp2_diff", 0, dd[0], 32'hEF);
        chk("bp2_borrow", 0, bo[0], 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a calculation.
        op0[0] = 32'hC3; op1[0] = 32'h3C; ival[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!irdy[0] && n < 200);
        @(posedge clk);
        #1 ival[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_irdy", 0, irdy[0], 1);
        chk("arst_oval", 0, oval[0], 0);
        chk("arst_diff", 0, dd[0], 0);
        chk("arst_borrow", 0, bo[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_op(0, 32'hAA, 32'h55, rd, rb, ro, rl);
        chk("diff_aa_55", 0, rd, 32'h55);
        chk("borrow_aa_55", 0, rb, 0);
        chk("lat_aa_55", 0, rl, 9);

        // Randomized operands and stalls on both widths concurrently.
        fork
            rand_drive(0);
            rand_drive(1);
        join
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
